// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 keyboard receiver.
// Parity checking is enabled by defining FPGA_ROBOTS_PS2_PARITY_EN.
package ps2_keyboard_rx_pkg;

    localparam int PS2_DATA_BITS         = 8;
    localparam int PS2_FRAME_BITS        = 11;
    localparam int PS2_FILT_LEN_DEF      = 4;
    localparam int PS2_TIMEOUT_TICKS_DEF = 25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer plus a persistence glitch filter for the PS/2 clock line.
// Emits a registered one-cycle pulse when the filtered level falls 1->0.
module ps2_sync_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic fall
);

    logic       meta;
    logic       sync;
    logic       filt;
    logic [3:0] cnt;

    // Flops reset to 1, the idle level of an open-collector PS/2 bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            filt <= 1'b1;
            cnt  <= 4'd0;
            fall <= 1'b0;
        end else begin
            meta <= line_in;
            sync <= meta;
            fall <= 1'b0;
            if (sync == filt) begin
                cnt <= 4'd0;
            end else if (cnt == 4'(FILT_LEN - 1)) begin
                filt <= sync;
                cnt  <= 4'd0;
                fall <= filt;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 device-to-host deserializer producing one strobe per good byte.
// Parity checking is enabled by defining FPGA_ROBOTS_PS2_PARITY_EN.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILT_LEN      = PS2_FILT_LEN_DEF,
    parameter int TIMEOUT_TICKS = PS2_TIMEOUT_TICKS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sixus,
    input  logic                     ps2_clk_in,
    input  logic                     ps2_dat_in,
    output logic [PS2_DATA_BITS-1:0] rx_dat,
    output logic                     rx_stb,
    output logic                     err_stb,
    output logic                     busy,
    output ps2_state_t               state_dbg
);

    // Handshake: rx_stb and err_stb are single-cycle, mutually exclusive
    // pulses with no ready; rx_dat is valid in the rx_stb cycle and holds after.

    logic                     fall;
    logic                     dat_meta;
    logic                     dat_sync;
    logic                     frame_good;
    logic                     timeout_hit;

    ps2_state_t               state;
    ps2_state_t               state_nxt;
    logic [2:0]               bitcnt;
    logic [2:0]               bitcnt_nxt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic [PS2_DATA_BITS-1:0] shreg_nxt;
    logic [5:0]               tocnt;
    logic [5:0]               tocnt_nxt;
    logic [PS2_DATA_BITS-1:0] rx_dat_nxt;
    logic                     rx_stb_nxt;
    logic                     err_stb_nxt;

    ps2_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk_in),
        .fall    (fall)
    );

    // Data only needs to be stable at the filtered edge, so no filter here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
        end
    end

`ifdef FPGA_ROBOTS_PS2_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (state == ST_PARITY && fall) begin
            par_q <= dat_sync;
        end
    end

    assign frame_good = dat_sync && ps2_parity_ok(shreg, par_q);
`else
    assign frame_good = dat_sync;
`endif

    assign timeout_hit = (tocnt == 6'(TIMEOUT_TICKS));
    assign state_dbg   = state;

    always_comb begin
        state_nxt   = state;
        bitcnt_nxt  = bitcnt;
        shreg_nxt   = shreg;
        tocnt_nxt   = tocnt;
        rx_dat_nxt  = rx_dat;
        rx_stb_nxt  = 1'b0;
        err_stb_nxt = 1'b0;

        if (state == ST_IDLE || fall) begin
            tocnt_nxt = 6'd0;
        end else if (sixus && !timeout_hit) begin
            tocnt_nxt = tocnt + 6'd1;
        end

        case (state)
            ST_IDLE: begin
                if (fall && !dat_sync) begin
                    state_nxt  = ST_DATA;
                    bitcnt_nxt = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shreg_nxt = {dat_sync, shreg[PS2_DATA_BITS-1:1]};
                    if (bitcnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                    if (frame_good) begin
                        rx_dat_nxt = shreg;
                        rx_stb_nxt = 1'b1;
                    end else begin
                        err_stb_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // An edge in the same cycle as the timeout keeps the frame alive.
        if (state != ST_IDLE && !fall && timeout_hit) begin
            state_nxt   = ST_IDLE;
            bitcnt_nxt  = 3'd0;
            shreg_nxt   = '0;
            tocnt_nxt   = 6'd0;
            err_stb_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bitcnt  <= 3'd0;
            shreg   <= '0;
            tocnt   <= 6'd0;
            rx_dat  <= '0;
            rx_stb  <= 1'b0;
            err_stb <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bitcnt  <= bitcnt_nxt;
            shreg   <= shreg_nxt;
            tocnt   <= tocnt_nxt;
            rx_dat  <= rx_dat_nxt;
            rx_stb  <= rx_stb_nxt;
            err_stb <= err_stb_nxt;
            busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: scenario tasks plus randomized frames checked against a frame-level model.
// Builds with or without FPGA_ROBOTS_PS2_PARITY_EN.
module tb_ps2_keyboard_rx;
    import ps2_keyboard_rx_pkg::*;

    localparam int H  = 16;  // PS/2 half bit period in system clocks
    localparam int TO = 25;
`ifdef FPGA_ROBOTS_PS2_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sixus = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       err_stb;
    logic       busy;
    ps2_state_t state_dbg;

    ps2_keyboard_rx dut (
        .clk        (clk),
        .rst        (rst),
        .sixus      (sixus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .rx_dat     (rx_dat),
        .rx_stb     (rx_stb),
        .err_stb    (err_stb),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset / tick block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tick_cnt = 0;
    initial begin
        forever begin
            repeat (7) @(posedge clk);
            #1 sixus = 1'b1;
            tick_cnt = tick_cnt + 1;
            @(posedge clk);
            #1 sixus = 1'b0;
        end
    end

    // ---------------- output monitor ----------------
    logic [7:0] got_q[$];
    int err_seen = 0, both_seen = 0, stb_cyc = 0, err_tick = 0;
    always @(negedge clk) begin
        if (rx_stb) begin
            got_q.push_back(rx_dat);
            stb_cyc <= cyc;
        end
        if (err_stb) begin
            err_seen <= err_seen + 1;
            err_tick <= tick_cnt;
        end
        if (rx_stb && err_stb) both_seen <= both_seen + 1;
    end

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    int tests_run = 0, fails = 0;
    int last_fall_cyc = 0, tick_at_fall = 0;

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic bit frame_good(input logic [7:0] d, input logic par, input logic stop);
        int ones;
        ones = $countones(d) + (par ? 1 : 0);
        return stop && (!PAR_EN || (ones % 2) == 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_in = f[i];
            if (i == glitch_bit) begin
                wait_cyc(4);
                ps2_clk_in = 1'b0;
                wait_cyc(2);
                ps2_clk_in = 1'b1;
                wait_cyc(H - 6);
            end else begin
                wait_cyc(H);
            end
            ps2_clk_in    = 1'b0;
            last_fall_cyc = cyc;
            tick_at_fall  = tick_cnt;
            wait_cyc(H);
            ps2_clk_in = 1'b1;
        end
        ps2_dat_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
        send_bits({stop, par, d, 1'b0}, 11, glitch_bit);
        wait_cyc(H);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        wait_cyc(5);
        tests_run++; if (rx_dat !== 8'h00) begin fails++; $display("FAIL reset_rx_dat got=%0h exp=00", rx_dat); end
        tests_run++; if (rx_stb !== 1'b0) begin fails++; $display("FAIL reset_rx_stb got=%0b exp=0", rx_stb); end
        tests_run++; if (err_stb !== 1'b0) begin fails++; $display("FAIL reset_err_stb got=%0b exp=0", err_stb); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        tests_run++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_good_byte();
        int g0, e0;
        g0 = got_q.size(); e0 = err_seen;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        wait_cyc(10);
        tests_run++; if (got_q.size() - g0 != 1) begin fails++; $display("FAIL good_count got=%0d exp=1", got_q.size() - g0); end
        tests_run++; if (got_q[g0] !== 8'h1C) begin fails++; $display("FAIL good_data got=%0h exp=1c", got_q[g0]); end
        tests_run++; if (err_seen != e0) begin fails++; $display("FAIL good_err got=%0d exp=0", err_seen - e0); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL good_busy got=%0b exp=0", busy); end
        tests_run++; if (rx_dat !== 8'h1C) begin fails++; $display("FAIL good_rx_dat got=%0h exp=1c", rx_dat); end
        tests_run++; if (stb_cyc - last_fall_cyc != 7) begin fails++; $display("FAIL good_latency got=%0d exp=7", stb_cyc - last_fall_cyc); end
    endtask

    task automatic test_bad_parity();
        int g0, e0, exp_n;
        g0 = got_q.size(); e0 = err_seen;
        exp_n = frame_good(8'h1C, 1'b1, 1'b1) ? 1 : 0;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        wait_cyc(10);
        tests_run++; if (got_q.size() - g0 != exp_n) begin fails++; $display("FAIL parity_count got=%0d exp=%0d", got_q.size() - g0, exp_n); end
        tests_run++; if (err_seen - e0 != 1 - exp_n) begin fails++; $display("FAIL parity_err got=%0d exp=%0d", err_seen - e0, 1 - exp_n); end
        tests_run++; if (rx_dat !== 8'h1C) begin fails++; $display("FAIL parity_rx_dat got=%0h exp=1c", rx_dat); end
    endtask

    task automatic test_glitch();
        int g0, e0;
        g0 = got_q.size(); e0 = err_seen;
        ps2_clk_in = 1'b0;
        wait_cyc(2);
        ps2_clk_in = 1'b1;
        wait_cyc(20);
        tests_run++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL glitch_idle_state got=%0d exp=0", state_dbg); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle_busy got=%0b exp=0", busy); end
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 4);
        wait_cyc(10);
        tests_run++; if (got_q.size() - g0 != 1) begin fails++; $display("FAIL glitch_count got=%0d exp=1", got_q.size() - g0); end
        tests_run++; if (got_q[g0] !== 8'hF0) begin fails++; $display("FAIL glitch_data got=%0h exp=f0", got_q[g0]); end
        tests_run++; if (err_seen != e0) begin fails++; $display("FAIL glitch_err got=%0d exp=0", err_seen - e0); end
    endtask

    task automatic test_timeout();
        int g0, e0, ticks, budget;
        g0 = got_q.size(); e0 = err_seen;
        send_bits({1'b1, odd_par(8'h33), 8'h33, 1'b0}, 5, -1);
        wait_cyc(4);
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_busy_mid got=%0b exp=1", busy); end
        tests_run++; if (state_dbg !== ST_DATA) begin fails++; $display("FAIL timeout_state_mid got=%0d exp=1", state_dbg); end
        budget = 2000;
        while (err_seen == e0 && budget > 0) begin
            wait_cyc(1);
            budget--;
        end
        wait_cyc(2);
        ticks = err_tick - tick_at_fall;
        tests_run++; if (err_seen - e0 != 1) begin fails++; $display("FAIL timeout_err got=%0d exp=1", err_seen - e0); end
        tests_run++; if (ticks < TO || ticks > TO + 1) begin fails++; $display("FAIL timeout_ticks got=%0d exp=%0d..%0d", ticks, TO, TO + 1); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
        tests_run++; if (got_q.size() != g0) begin fails++; $display("FAIL timeout_rx got=%0d exp=0", got_q.size() - g0); end
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, -1);
        wait_cyc(10);
        tests_run++; if (got_q[g0] !== 8'h5A) begin fails++; $display("FAIL timeout_next got=%0h exp=5a", got_q[g0]); end
    endtask

    task automatic test_reset_mid();
        int g0, e0;
        logic [10:0] f;
        f = {1'b1, odd_par(8'hA5), 8'hA5, 1'b0};
        send_bits(f, 6, -1);
        ps2_dat_in = f[6];
        wait_cyc(H);
        ps2_clk_in = 1'b0;
        wait_cyc(10);
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_pre got=%0b exp=1", busy); end
        g0 = got_q.size(); e0 = err_seen;
        rst = 1'b0;
        #1;
        tests_run++; if (rx_dat !== 8'h00) begin fails++; $display("FAIL rstmid_rx_dat got=%0h exp=00", rx_dat); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        tests_run++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL rstmid_state got=%0d exp=0", state_dbg); end
        wait_cyc(5);
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(40);
        tests_run++; if (got_q.size() != g0 || err_seen != e0) begin fails++; $display("FAIL rstmid_strobe got=%0d/%0d exp=0/0", got_q.size() - g0, err_seen - e0); end
        send_frame(8'hE0, odd_par(8'hE0), 1'b1, -1);
        send_frame(8'h75, odd_par(8'h75), 1'b1, -1);
        wait_cyc(10);
        tests_run++; if (got_q.size() - g0 != 2) begin fails++; $display("FAIL b2b_count got=%0d exp=2", got_q.size() - g0); end
        tests_run++; if (got_q[g0] !== 8'hE0) begin fails++; $display("FAIL b2b_first got=%0h exp=e0", got_q[g0]); end
        tests_run++; if (got_q[g0+1] !== 8'h75) begin fails++; $display("FAIL b2b_second got=%0h exp=75", got_q[g0+1]); end
    endtask

    task automatic test_stop_error();
        int g0, e0;
        g0 = got_q.size(); e0 = err_seen;
        send_frame(8'h29, odd_par(8'h29), 1'b0, -1);
        wait_cyc(10);
        tests_run++; if (err_seen - e0 != 1) begin fails++; $display("FAIL stop_err got=%0d exp=1", err_seen - e0); end
        tests_run++; if (got_q.size() != g0) begin fails++; $display("FAIL stop_rx got=%0d exp=0", got_q.size() - g0); end
        tests_run++; if (rx_dat !== 8'h75) begin fails++; $display("FAIL stop_rx_dat got=%0h exp=75", rx_dat); end
    endtask

    task automatic test_random();
        int g0, e0, exp_err, gb;
        logic [7:0] d;
        logic par, stop;
        g0 = got_q.size(); e0 = err_seen; exp_err = 0;
        exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            par  = odd_par(d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            gb   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            if (frame_good(d, par, stop)) exp_q.push_back(d);
            else exp_err++;
            send_frame(d, par, stop, gb);
        end
        wait_cyc(10);
        tests_run++; if (got_q.size() - g0 != exp_q.size()) begin fails++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
        tests_run++; if (err_seen - e0 != exp_err) begin fails++; $display("FAIL rand_err got=%0d exp=%0d", err_seen - e0, exp_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++; if (got_q[g0+i] !== exp_q[i]) begin fails++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, got_q[g0+i], exp_q[i]); end
        end
        tests_run++; if (both_seen != 0) begin fails++; $display("FAIL strobe_exclusive got=%0d exp=0", both_seen); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_byte();
        test_bad_parity();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_stop_error();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receive-only PS/2 device-to-host deserializer. Samples the raw PS/2 clock and data lines of port A and recovers 11-bit frames: start bit, 8 data bits LSB first, odd parity, stop bit. Each good byte is emitted as a one-cycle strobe. The block sits directly upstream of `fpga_robots_game_control` and drives its `ps2_rx_dat`/`ps2_rx_stb` inputs, replacing the current tie-offs.

## Interface
- `FILT_LEN`, default 4: consecutive identical synchronized samples required before the filtered PS/2 clock changes level; range 2..15.
- `TIMEOUT_TICKS`, default 25: number of `sixus` ticks with no filtered-clock falling edge that aborts a frame in progress (about 150 µs); range 2..63.
- `clk`  in  1  system clock, about 65 MHz.
- `rst`  in  1  reset, asynchronous, active-low: 0 resets the block.
- `sixus`  in  1  one-cycle tick every 6 µs, from `fpga_robots_game_clock`.
- `ps2_clk_in`  in  1  raw PS/2 clock pin. Asynchronous; the top level tristates the pad.
- `ps2_dat_in`  in  1  raw PS/2 data pin. Asynchronous.
- `rx_dat`  out  8  last received byte.
- `rx_stb`  out  1  one-cycle pulse: `rx_dat` is newly valid.
- `err_stb`  out  1  one-cycle pulse: a frame was discarded.
- `busy`  out  1  high while a frame is in progress (state is not IDLE).

## Operation
- **Synchronizer:** both raw inputs go through 2-flop synchronizers. The synchronizer flops reset to 1, the bus idle level.
- **Clock filter:** a counter tracks how long the synchronized clock has differed from the filtered clock. When the difference persists for `FILT_LEN` consecutive cycles, the filtered clock takes the new level. Any matching sample clears the counter. The filtered clock resets to 1.
- **Falling edge:** a falling edge is the filtered clock going 1→0. On that cycle the synchronized data is sampled.
- **State machine:**
  - IDLE: on an edge with data = 0 (start bit), go to DATA and set `bitcnt` = 0. An edge with data = 1 is ignored and the state stays IDLE.
  - DATA: each edge shifts the sampled bit into `shreg[7]` and shifts the register right. When `bitcnt` reaches 7, go to PARITY; otherwise increment `bitcnt`.
  - PARITY: on an edge, latch the sampled parity bit and go to STOP.
  - STOP: on an edge, check the frame. A frame is good when stop = 1 and (XOR of the 8 data bits XOR parity) = 1. Good frame: load `rx_dat`, pulse `rx_stb`. Bad frame: pulse `err_stb`. Either way, return to IDLE.
- **Timeout:** `tocnt` is 6 bits. It clears on every edge and while in IDLE. Otherwise it increments on `sixus`. When it reaches `TIMEOUT_TICKS`: go to IDLE, pulse `err_stb`, and discard the partial frame.
- **Priority:** a falling edge and a timeout in the same cycle resolve as edge wins; no timeout is taken.
- **Strobe exclusivity:** `rx_stb` and `err_stb` are never high in the same cycle.
- **Reset mid-frame:** asserting `rst` at any point forces IDLE immediately and clears every counter and output. No strobe is produced for the aborted frame.
- **Reset values:**
  - `rx_dat` = 8'h00
  - `rx_stb` = 0
  - `err_stb` = 0
  - `busy` = 0
  - state = IDLE
  - `bitcnt` = 0, `tocnt` = 0, `shreg` = 0

## Timing
- All outputs are registered.
- The filtered clock falls `FILT_LEN`+2 cycles after the raw clock is first sampled low.
- Strobe latency: `rx_stb`/`err_stb` go high exactly 1 cycle after the edge cycle that samples the stop bit. `rx_dat` changes in that same cycle.
- Total latency is therefore `FILT_LEN`+3 cycles from the raw falling edge, which is 7 cycles at the default `FILT_LEN`.
- `rx_dat` holds its value until the next good frame.
- There is no back-pressure. The consumer must accept a strobe in the cycle it occurs. Byte spacing is at least about 1 ms, so this is safe.
- `busy` rises 1 cycle after the start-bit edge and falls in the same cycle the strobe rises.
- The data line needs ≥5 µs setup before the clock edge (per PS/2), which far exceeds the filter delay (about 100 ns).

## Configuration
- `FPGA_ROBOTS_PS2_PARITY_EN`
  - **Defined:** parity is checked as described above. A bad parity bit discards the byte and pulses `err_stb`.
  - **Undefined:** the parity bit is still clocked through the PARITY state but ignored. Only a bad stop bit or a timeout produces `err_stb`.
- The macro is defined by default in `fpga_robots_game_config.v`.

## Structure
- **Shared package / include file:** frame constants (`PS2_DATA_BITS` = 8, frame length 11), the state encoding (IDLE=0, DATA=1, PARITY=2, STOP=3), and the default `TIMEOUT_TICKS`.
- **Sub-module `ps2_sync_filter`:** the 2-flop synchronizer plus the `FILT_LEN` glitch filter, with a registered falling-edge pulse output. It is instantiated once for the clock line. The data line uses only a plain 2-flop synchronizer.
- The frame state machine, shift register, parity check and timeout live in `ps2_keyboard_rx` itself.

## Test plan
- **Good byte:** send frame 0x1C (parity 0) at 12.5 kHz → one `rx_stb`, `rx_dat` = 0x1C, `err_stb` never high, `busy` low afterwards.
- **Bad parity:** send 0x1C with parity 1 → `err_stb` pulses once, no `rx_stb`, `rx_dat` unchanged. With `FPGA_ROBOTS_PS2_PARITY_EN` undefined → `rx_stb` pulses with 0x1C.
- **Glitch rejection:** a 2-cycle low glitch on the clock in IDLE and mid-frame → no edge counted. A following 0xF0 frame decodes correctly.
- **Timeout:** stop the clock after 4 data bits → `err_stb` pulses 25 `sixus` ticks after the last edge, `busy` falls. A following 0x5A frame decodes to 0x5A.
- **Reset mid-frame:** assert `rst` = 0 during bit 5 → outputs go to their reset values immediately, no strobe. After release, 0xE0 then 0x75 back-to-back → two `rx_stb` pulses in order.
- **Stop-bit error:** send 0x29 with stop = 0 → `err_stb` pulses, no `rx_stb`.
